// File: rtl/uart_rx_deser_check.sv
// UART RX frame checker: consumes one majority-voted bit per strobe, checks the
// start bit, deserialises LSB-first data, optionally checks parity, checks the
// stop bit, and emits a one-cycle data_valid or error pulse per frame.
module uart_rx_deser_check #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sampled_bit,
    input  logic                  sample_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  acc_q, acc_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;
    logic                  sg_q, sg_d;
    logic                  busy_q, busy_d;

    // Frame FSM next-state; nothing moves except on a strobe, pulses default low.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        p_data_d  = p_data_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        sg_d      = 1'b0;

        if (sample_valid) begin
            case (state_q)
                StIdle: begin
                    if (!sampled_bit) begin
                        state_d   = StData;
                        cnt_d     = '0;
                        acc_d     = 1'b0;
                        par_bad_d = 1'b0;
                        // Parity mode is frozen for the whole frame.
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                    end else begin
                        sg_d = 1'b1;
                    end
                end
                StData: begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    acc_d   = acc_q ^ sampled_bit;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
                        state_d = par_en_q ? StParity : StStop;
                    end
                end
                StParity: begin
                    par_bad_d = (sampled_bit != (acc_q ^ par_typ_q));
                    state_d   = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!par_bad_q && sampled_bit) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end else begin
                        pe_d = par_bad_q;
                        se_d = ~sampled_bit;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
            sg_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            p_data_q  <= p_data_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
            sg_q      <= sg_d;
            busy_q    <= busy_d;
        end
    end

    assign P_DATA      = p_data_q;
    assign data_valid  = dv_q;
    assign par_err     = pe_q;
    assign stp_err     = se_q;
    assign strt_glitch = sg_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deser_check.sv
// Scoreboard bench for uart_rx_deser_check: stimulus tasks push expected pulses
// computed from frame contents; a negedge monitor pops and compares each pulse.
module tb_uart_rx_deser_check;

    logic       CLK;
    logic       RST;
    logic       sampled_bit;
    logic       sample_valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
    logic       busy;

    uart_rx_deser_check #(.DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .strt_glitch  (strt_glitch),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // flags = {data_valid, par_err, stp_err, strt_glitch}
    typedef struct packed {
        logic [3:0] flags;
        logic [7:0] pdata;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model_pdata;
    int         tests;
    int         fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Parity bit that makes the total count of ones even (typ=0) or odd (typ=1).
    function automatic logic calc_parity(input logic [7:0] d, input logic typ);
        int ones;
        ones = $countones(d) + int'(typ);
        return logic'(ones % 2);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic strobe(input logic b, input int gap);
        repeat (gap) @(negedge CLK);
        sampled_bit  = b;
        sample_valid = 1'b1;
        @(negedge CLK);
        sample_valid = 1'b0;
        sampled_bit  = logic'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stop, input int maxgap);
        logic par_bad;
        logic stop_bad;
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        strobe(1'b0, $urandom_range(0, maxgap));
        // Scramble the parity controls; the frame must keep the values seen at start.
        PAR_EN  = logic'($urandom_range(0, 1));
        PAR_TYP = logic'($urandom_range(0, 1));
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) strobe(d[i], $urandom_range(0, maxgap));
        if (pen) strobe(pbit, $urandom_range(0, maxgap));
        par_bad  = pen && (pbit != calc_parity(d, ptyp));
        stop_bad = !stop;
        if (!par_bad && !stop_bad) begin
            model_pdata = d;
            exp_q.push_back('{flags: 4'b1000, pdata: d});
        end else begin
            exp_q.push_back('{flags: {1'b0, par_bad, stop_bad, 1'b0}, pdata: model_pdata});
        end
        strobe(stop, $urandom_range(0, maxgap));
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic send_glitch(input int gap);
        exp_q.push_back('{flags: 4'b0001, pdata: model_pdata});
        strobe(1'b1, gap);
        check("busy_after_glitch", 32'(busy), 32'd0);
    endtask

    // Monitor: every cycle with a pulse must match the oldest expected event.
    always @(negedge CLK) begin
        if (RST && (data_valid || par_err || stp_err || strt_glitch)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got flags %b, required none",
                         {data_valid, par_err, stp_err, strt_glitch});
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_flags", 32'({data_valid, par_err, stp_err, strt_glitch}),
                      32'(mon_e.flags));
                check("p_data", 32'(P_DATA), 32'(mon_e.pdata));
            end
        end
    end

    initial begin
        tests        = 0;
        fails        = 0;
        model_pdata  = 8'h00;
        RST          = 1'b0;
        sampled_bit  = 1'b0;
        sample_valid = 1'b0;
        PAR_EN       = 1'b0;
        PAR_TYP      = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", 32'({P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}),
              32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // 1: good frame with even parity
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        check("s1_p_data", 32'(P_DATA), 32'hA5);

        // 2: odd parity expected, parity bit 0 sent
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        check("s2_p_data_held", 32'(P_DATA), 32'hA5);

        // 3: stop error, then back-to-back good frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("s3_p_data", 32'(P_DATA), 32'h3C);

        // 4: false start then good frame
        send_glitch(0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("s4_p_data", 32'(P_DATA), 32'h81);

        // 5: reset after four data bits
        PAR_EN = 1'b0;
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(logic'($urandom_range(0, 1)), 0);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("s5_reset_outputs",
              32'({P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}), 32'd0);
        model_pdata = 8'h00;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("s5_p_data", 32'(P_DATA), 32'h55);

        // 6: long random gaps between strobes
        send_frame(8'hC3, 1'b1, 1'b0, calc_parity(8'hC3, 1'b0), 1'b1, 40);
        check("s6_p_data", 32'(P_DATA), 32'hC3);

        // Random frames, glitches and error injections
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       pen;
            logic       ptyp;
            logic       pbit;
            logic       stop;
            if ($urandom_range(0, 5) == 0) begin
                send_glitch($urandom_range(0, 3));
            end else begin
                d    = 8'($urandom_range(0, 255));
                pen  = logic'($urandom_range(0, 1));
                ptyp = logic'($urandom_range(0, 1));
                pbit = calc_parity(d, ptyp) ^ ($urandom_range(0, 3) == 0);
                stop = ($urandom_range(0, 3) != 0);
                send_frame(d, pen, ptyp, pbit, stop, 3);
                check("rand_p_data", 32'(P_DATA), 32'(model_pdata));
            end
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
